// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types and I2S frame constants
// Contents:
//   sample_t        signed 16-bit PCM sample
//   stereo_t        packed {l, r} sample pair
//   I2S_FRAME_CLKS  master clocks per 48 kHz frame
//   I2S_SLOT_BITS   bit clocks per channel slot
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  localparam int I2S_FRAME_CLKS = 256;
  localparam int I2S_SLOT_BITS  = 32;

endpackage

// File: rtl/i2s_bit_timer.sv
// rtl/i2s_bit_timer.sv - frame counter and registered I2S bit/word clocks
// Ports:
//   clk, reset_n   audio master clock, async active-low reset
//   sclk           registered bit clock (low first half of each bit period)
//   lrck           registered word select (0 left, 1 right)
//   slot           current slot index decoded from the counter (unregistered)
//   bit_pos        current position within the slot (unregistered)
//   shift_en       first clk of a bit period, i.e. the cycle that produces sclk fall
//   frame_load     last clk of the frame
module i2s_bit_timer #(
  parameter int SCLK_DIV  = 4,
  parameter int SLOT_BITS = 32,
  localparam int FRAME    = 2 * SLOT_BITS * SCLK_DIV,
  localparam int CW       = $clog2(FRAME),
  localparam int BW       = $clog2(SLOT_BITS)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          sclk,
  output logic          lrck,
  output logic          slot,
  output logic [BW-1:0] bit_pos,
  output logic          shift_en,
  output logic          frame_load
);

  logic [CW-1:0] cnt;
  int            c_i;
  int            phase_i;
  int            period_i;
  int            pos_i;

  always_comb begin
    c_i      = int'(cnt);
    phase_i  = c_i % SCLK_DIV;
    period_i = c_i / SCLK_DIV;
    pos_i    = period_i % SLOT_BITS;
  end

  assign slot       = (period_i >= SLOT_BITS);
  assign bit_pos    = BW'(pos_i);
  assign shift_en   = (phase_i == 0);
  assign frame_load = (c_i == FRAME - 1);

  // sclk/lrck are registered from the current count so they lag it by one
  // clk, matching the dac register in the parent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
      lrck <= 1'b0;
    end else begin
      cnt  <= frame_load ? '0 : cnt + CW'(1);
      sclk <= (phase_i >= SCLK_DIV / 2);
      lrck <= slot;
    end
  end

endmodule

// File: rtl/pocket_i2s_tx.sv
// rtl/pocket_i2s_tx.sv - I2S transmitter with one-deep sample holding register
// Optional build macro: I2S_UNDERRUN_MUTE_EN (underrun frames play silence
// instead of repeating the previous pair).
// Ports:
//   clk, reset_n          12.288 MHz audio master clock, async active-low reset
//   sample_l, sample_r    signed PCM pair from the sound path
//   sample_valid          producer presents a pair
//   sample_ready          holding register empty
//   i2s_sclk, i2s_lrck    bit clock and word select
//   i2s_dac               serial data, MSB first with one-bit I2S delay
//   underrun_count        saturating count of frames started with no pair held
module pocket_i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = $bits(sample_t),
  parameter int SCLK_DIV     = I2S_FRAME_CLKS / (2 * I2S_SLOT_BITS),
  parameter int SLOT_BITS    = I2S_SLOT_BITS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_l,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  output logic                           i2s_sclk,
  output logic                           i2s_lrck,
  output logic                           i2s_dac,
  output logic [15:0]                    underrun_count
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int BW = $clog2(SLOT_BITS);
  localparam int IW = (SW > 1) ? $clog2(SW) : 1;

  logic          slot;
  logic [BW-1:0] bit_pos;
  logic          shift_en;
  logic          frame_load;

  logic [2*SW-1:0] holding;
  logic [2*SW-1:0] frame;
  logic            full;
  logic            accept;

  logic [SW-1:0] slot_sample;
  logic [IW-1:0] bit_idx;
  logic          dac_next;
  int            pos_i;

  i2s_bit_timer #(
    .SCLK_DIV  (SCLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .sclk       (i2s_sclk),
    .lrck       (i2s_lrck),
    .slot       (slot),
    .bit_pos    (bit_pos),
    .shift_en   (shift_en),
    .frame_load (frame_load)
  );

  assign sample_ready = ~full;
  assign accept       = sample_valid && !full;

  // Slot bit 0 is the I2S one-bit delay; sample occupies bits 1..SW MSB first.
  always_comb begin
    slot_sample = slot ? frame[SW-1:0] : frame[2*SW-1:SW];
    pos_i       = int'(bit_pos);
    bit_idx     = '0;
    dac_next    = 1'b0;
    if (pos_i >= 1 && pos_i <= SW) begin
      bit_idx  = IW'(SW - pos_i);
      dac_next = slot_sample[bit_idx];
    end
  end

  // Accept and a full-frame load never collide: accept needs full==0 while
  // draining the holding register needs full==1. A pair accepted on the load
  // cycle itself stays in holding and that frame is an underrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holding        <= '0;
      frame          <= '0;
      full           <= 1'b0;
      underrun_count <= '0;
      i2s_dac        <= 1'b0;
    end else begin
      if (accept) begin
        holding <= {sample_l, sample_r};
        full    <= 1'b1;
      end
      if (frame_load) begin
        if (full) begin
          frame <= holding;
          full  <= 1'b0;
        end else begin
          if (underrun_count != 16'hFFFF) begin
            underrun_count <= underrun_count + 16'd1;
          end
`ifdef I2S_UNDERRUN_MUTE_EN
          frame <= '0;
`else
          frame <= frame;
`endif
        end
      end
      if (shift_en) begin
        i2s_dac <= dac_next;
      end
    end
  end

endmodule

// File: tb/tb_pocket_i2s_tx.sv
// tb/tb_pocket_i2s_tx.sv - scoreboard bench for pocket_i2s_tx
module tb_pocket_i2s_tx;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  sample_t     sample_l;
  sample_t     sample_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        i2s_sclk;
  logic        i2s_lrck;
  logic        i2s_dac;
  logic [15:0] underrun_count;

  always #5 clk = ~clk;

  pocket_i2s_tx dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample_l       (sample_l),
    .sample_r       (sample_r),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .i2s_sclk       (i2s_sclk),
    .i2s_lrck       (i2s_lrck),
    .i2s_dac        (i2s_dac),
    .underrun_count (underrun_count)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Serial image of one frame as received, first bit in the MSB.
  function automatic logic [63:0] fw(input sample_t l, input sample_t r);
    return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: samples dac/lrck on every sclk rise, compares each full frame.
  logic        mon_prev_sclk = 1'b0;
  logic [63:0] mon_data = '0;
  logic [63:0] mon_lr = '0;
  int          mon_bits = 0;
  logic [63:0] mon_exp;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_prev_sclk = 1'b0;
      mon_bits      = 0;
      mon_data      = '0;
      mon_lr        = '0;
    end else begin
      if (i2s_sclk && !mon_prev_sclk) begin
        mon_data = {mon_data[62:0], i2s_dac};
        mon_lr   = {mon_lr[62:0], i2s_lrck};
        mon_bits++;
        if (mon_bits == 64) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: got %0h expected no frame", mon_data);
          end else begin
            mon_exp = exp_q.pop_front();
            check("frame_data", mon_data, mon_exp);
            check("frame_lrck", mon_lr, 64'h0000_0000_FFFF_FFFF);
          end
          mon_bits = 0;
        end
      end
      mon_prev_sclk = i2s_sclk;
    end
  end

  stereo_t pairs [4];
  int      last_lr, last_sc, sc_rises, sc_bad, nacc, last_acc, ready_hi;
  logic    prev_lr, prev_sc, acc;

  initial begin
    pairs[0] = '{l: 16'h0001, r: 16'hFFFF};
    pairs[1] = '{l: 16'hA5A5, r: 16'h5A5A};
    pairs[2] = '{l: 16'h7FFF, r: 16'h8000};
    pairs[3] = '{l: 16'h00FF, r: 16'hFF00};
    sample_l     = '0;
    sample_r     = '0;
    sample_valid = 1'b0;

    // Idle after reset: clocks run, silence, one underrun per frame.
    do_reset();
    check("rst_sclk", i2s_sclk, 0);
    check("rst_lrck", i2s_lrck, 0);
    check("rst_dac", i2s_dac, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_underrun", underrun_count, 0);
    repeat (3) exp_q.push_back(64'h0);
    last_lr = -1; last_sc = -1; sc_rises = 0; sc_bad = 0;
    prev_lr = 1'b0; prev_sc = 1'b0;
    for (int k = 0; k < 768; k++) begin
      step();
      if (i2s_lrck !== prev_lr) begin
        if (last_lr >= 0) check("lrck_interval", k - last_lr, 128);
        last_lr = k;
      end
      prev_lr = i2s_lrck;
      if (i2s_sclk && !prev_sc) begin
        if (last_sc >= 0 && (k - last_sc) != 4) sc_bad++;
        sc_rises++;
        last_sc = k;
      end
      prev_sc = i2s_sclk;
      if (k == 254) check("t1_ur_before_load", underrun_count, 0);
      if (k == 255) check("t1_ur_load1", underrun_count, 1);
      if (k == 511) check("t1_ur_load2", underrun_count, 2);
    end
    check("t1_sclk_rises", sc_rises, 192);
    check("t1_sclk_bad_periods", sc_bad, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Single pair before the first load, then starve.
    do_reset();
    exp_q.push_back(64'h0);
    exp_q.push_back(fw(16'h8001, 16'h7FFE));
`ifdef I2S_UNDERRUN_MUTE_EN
    exp_q.push_back(64'h0);
`else
    exp_q.push_back(fw(16'h8001, 16'h7FFE));
`endif
    sample_l = 16'h8001; sample_r = 16'h7FFE; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("t2_ready_after_accept", sample_ready, 0);
    for (int k = 1; k < 768; k++) begin
      step();
      if (k == 254) check("t2_ready_before_load", sample_ready, 0);
      if (k == 255) begin
        check("t2_ready_after_load", sample_ready, 1);
        check("t2_ur_load1", underrun_count, 0);
      end
      if (k == 511) check("t2_ur_load2", underrun_count, 1);
    end
    check("t2_queue_empty", exp_q.size(), 0);

    // valid held high: one accept per frame, no drops or duplicates.
    do_reset();
    exp_q.push_back(64'h0);
    nacc = 0; last_acc = -1; ready_hi = 0;
    sample_l = pairs[0].l; sample_r = pairs[0].r; sample_valid = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      acc = sample_ready;
      step();
      if (acc) begin
        if (last_acc >= 0) check("t3_accept_interval", k - last_acc, 256);
        if (nacc < 3) exp_q.push_back(fw(pairs[nacc].l, pairs[nacc].r));
        nacc++;
        last_acc = k;
        if (nacc < 4) begin
          sample_l = pairs[nacc].l;
          sample_r = pairs[nacc].r;
        end
      end
      if (sample_ready) ready_hi++;
    end
    sample_valid = 1'b0;
    check("t3_accepts", nacc, 4);
    check("t3_ready_high_cycles", ready_hi, 4);
    check("t3_underrun", underrun_count, 0);
    check("t3_queue_empty", exp_q.size(), 0);

    // Pair presented only on the load cycle: underrun, plays one frame later.
    do_reset();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    exp_q.push_back(fw(16'hC3C3, 16'h3C3C));
    for (int k = 0; k < 768; k++) begin
      if (k == 255) begin
        sample_l = 16'hC3C3; sample_r = 16'h3C3C; sample_valid = 1'b1;
      end
      step();
      if (k == 255) begin
        sample_valid = 1'b0;
        check("t4_ur_load_cycle", underrun_count, 1);
        check("t4_ready_held", sample_ready, 0);
      end
      if (k == 766) check("t4_ur_before_3rd", underrun_count, 1);
      if (k == 767) check("t4_ur_after_3rd", underrun_count, 2);
    end
    check("t4_queue_empty", exp_q.size(), 0);

    // Play 1234/4321 then starve.
    do_reset();
    exp_q.push_back(64'h0);
    exp_q.push_back(fw(16'h1234, 16'h4321));
`ifdef I2S_UNDERRUN_MUTE_EN
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
`else
    exp_q.push_back(fw(16'h1234, 16'h4321));
    exp_q.push_back(fw(16'h1234, 16'h4321));
`endif
    sample_l = 16'h1234; sample_r = 16'h4321; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    for (int k = 1; k < 1024; k++) step();
    check("t5_underrun", underrun_count, 3);
    check("t5_queue_empty", exp_q.size(), 0);

    // Async reset mid left slot, then saturation of underrun_count.
    do_reset();
    sample_l = 16'hAB12; sample_r = 16'h34CD; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    for (int k = 1; k <= 70; k++) step();
    check("t6_sclk_pre_reset", i2s_sclk, 1);
    check("t6_ready_pre_reset", sample_ready, 0);
    #1 reset_n = 1'b0;
    #1;
    check("t6_async_sclk", i2s_sclk, 0);
    check("t6_async_lrck", i2s_lrck, 0);
    check("t6_async_dac", i2s_dac, 0);
    check("t6_async_ready", sample_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("t6_ready_release", sample_ready, 1);
    repeat (3) exp_q.push_back(64'h0);
    for (int k = 0; k < 768; k++) begin
      step();
      if (k == 1) check("t6_sclk_low_k1", i2s_sclk, 0);
      if (k == 2) begin
        check("t6_first_rise_sclk", i2s_sclk, 1);
        check("t6_first_rise_lrck", i2s_lrck, 0);
      end
      if (k == 255) check("t6_ur_after_reset", underrun_count, 1);
      if (k == 300) force dut.underrun_count = 16'hFFFE;
      if (k == 301) release dut.underrun_count;
      if (k == 511) check("t6_ur_saturate", underrun_count, 16'hFFFF);
      if (k == 767) check("t6_ur_hold_sat", underrun_count, 16'hFFFF);
    end
    check("t6_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
